// File: rtl/ram_pkg.sv
// Shared types for the data RAM responder and its write buffer.
package ram_pkg;

  localparam int WORD_BYTES = 4;
  localparam int IDX_W = 30;

  typedef logic [31:0] word_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    idx_t  idx;
    word_t data;
  } wbuf_entry_t;

  // Byte address to word index, folded modulo the array size.
  function automatic idx_t word_idx(
    input word_t addr,
    input int    aw
  );
    idx_t raw;
    idx_t msk;
    raw = idx_t'(addr >> $clog2(WORD_BYTES));
    msk = (idx_t'(1) << aw) - idx_t'(1);
    return raw & msk;
  endfunction

endpackage

// File: rtl/data_ram_wbuf.sv
// Posted-write FIFO with a youngest-match search port for read forwarding.
module data_ram_wbuf
  import ram_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  wbuf_entry_t   push_entry_i,
  input  logic          pop_i,
  output wbuf_entry_t   head_entry_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  input  idx_t          search_idx_i,
  output logic          hit_o,
  output word_t         hit_data_o
);

  wbuf_entry_t   ent_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_i)
      head_d = head_q + PW'(1);
    if (push_i)
      tail_d = tail_q + PW'(1);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i)
      ent_q[tail_q] <= push_entry_i;
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] pos;
    hit_o      = 1'b0;
    hit_data_o = '0;
    pos        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pos = head_q + PW'(i);
      if (CW'(i) < count_q &&
          ent_q[pos].idx == search_idx_i) begin
        hit_o      = 1'b1;
        hit_data_o = ent_q[pos].data;
      end
    end
  end

  assign head_entry_o = ent_q[head_q];
  assign count_o      = count_q;
  assign full_o       = full_q;
  assign empty_o      = (count_q == '0);

endmodule

// File: rtl/data_ram_responder.sv
// Data RAM responder: 1-cycle reads, posted write buffer with forwarding.
// Define DATA_RAM_STATS_EN to add rd/wr/fwd 32-bit counters.
module data_ram_responder
  import ram_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WBUF_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_ram_en,
  input  logic [31:0] rd_ram_addr,
  output logic [31:0] rd_ram_data,
  input  logic        wr_ram_en,
  input  logic [31:0] wr_ram_addr,
  input  logic [31:0] wr_ram_data,
  output logic        wbuf_full,
  output logic        wr_overflow,
  output logic        misaligned
`ifdef DATA_RAM_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] fwd_count
`endif
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(WBUF_DEPTH) + 1;

  word_t         mem_q [DEPTH_WORDS];
  idx_t          rd_idx, wr_idx;
  wbuf_entry_t   push_ent, head_ent;
  logic [CW-1:0] wb_count;
  logic          wb_full, wb_empty;
  logic          hit;
  word_t         hit_data;
  logic          drain, push;
  word_t         rd_data_q;
  logic          ovf_q, ovf_d;
  logic          mis_q, mis_d;
  logic          unused;

  assign rd_idx   = word_idx(rd_ram_addr, ADDR_W);
  assign wr_idx   = word_idx(wr_ram_addr, ADDR_W);
  assign push_ent = '{idx: wr_idx, data: wr_ram_data};

  // Reads own the single array port; drains only use idle cycles.
  assign drain = !wb_empty && !rd_ram_en;
  assign push  = wr_ram_en && (!wb_full || drain);

  data_ram_wbuf #(
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_ent),
    .pop_i        (drain),
    .head_entry_o (head_ent),
    .count_o      (wb_count),
    .full_o       (wb_full),
    .empty_o      (wb_empty),
    .search_idx_i (rd_idx),
    .hit_o        (hit),
    .hit_data_o   (hit_data)
  );

  always_ff @(posedge clk) begin
    if (drain)
      mem_q[head_ent.idx[ADDR_W-1:0]] <= head_ent.data;
  end

  always_comb begin
    ovf_d = ovf_q | (wr_ram_en & ~push);
    mis_d = mis_q
          | (rd_ram_en & (rd_ram_addr[1:0] != 2'b00))
          | (wr_ram_en & (wr_ram_addr[1:0] != 2'b00));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      if (rd_ram_en)
        rd_data_q <= hit ? hit_data
                         : mem_q[rd_idx[ADDR_W-1:0]];
      ovf_q <= ovf_d;
      mis_q <= mis_d;
    end
  end

  assign rd_ram_data = rd_data_q;
  assign wbuf_full   = wb_full;
  assign wr_overflow = ovf_q;
  assign misaligned  = mis_q;

`ifdef DATA_RAM_STATS_EN
  word_t rd_cnt_q, wr_cnt_q, fwd_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      fwd_cnt_q <= '0;
    end else begin
      if (rd_ram_en)
        rd_cnt_q <= rd_cnt_q + 32'd1;
      if (push)
        wr_cnt_q <= wr_cnt_q + 32'd1;
      if (rd_ram_en && hit)
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
    end
  end

  assign rd_count  = rd_cnt_q;
  assign wr_count  = wr_cnt_q;
  assign fwd_count = fwd_cnt_q;
`endif

  assign unused = ^{wb_count,
                    rd_idx[IDX_W-1:ADDR_W],
                    head_ent.idx[IDX_W-1:ADDR_W]};

endmodule
